// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory responder.
//   - MMIO word offsets within the 16-byte MMIO window
//   - run/halt state encoding
//   - address-decode result encoding
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam logic [3:0] OFF_TOHOST = 4'h0;
   localparam logic [3:0] OFF_CYCLE  = 4'h4;
   localparam logic [3:0] OFF_WRCNT  = 4'h8;
   localparam logic [3:0] OFF_STATUS = 4'hC;

   typedef enum logic {
      ST_RUN,
      ST_HALTED
   } state_e;

   typedef enum logic [1:0] {
      DEC_RAM,
      DEC_MMIO,
      DEC_NONE
   } dec_e;

endpackage

// File: rtl/dmem_sram.sv
// -----------------------------------------------------------------------------
// dmem_sram
// DEPTH_WORDS x 32 word RAM with synchronous write and registered read.
// A read and a write to the same word in one cycle returns the write data.
// The read register holds its value while re is low.
// Ports:
//   clk    in   clock
//   we     in   write enable (already gated by the caller)
//   waddr  in   write word index
//   wdata  in   write data
//   re     in   read enable
//   raddr  in   read word index
//   rdata  out  registered read data
// -----------------------------------------------------------------------------
module dmem_sram #(
   parameter int DEPTH_WORDS = 4096
) (
   input  logic                           clk,
   input  logic                           we,
   input  logic [$clog2(DEPTH_WORDS)-1:0] waddr,
   input  logic [31:0]                    wdata,
   input  logic                           re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] raddr,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rdata_q;
   logic [31:0] rdata_d;

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         // write-first: a same-cycle write to the read word wins
         if (we && (waddr == raddr)) begin
            rdata_d = wdata;
         end else begin
            rdata_d = mem[raddr];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata_q <= rdata_d;
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Memory-side responder for the core's data port: word RAM plus a 16-byte
// MMIO window (TOHOST, CYCLE, WRCNT, STATUS) and a RUN/HALTED machine that
// stops all writes once a nonzero value reaches TOHOST.
// Ports:
//   clk         in   clock, rising edge
//   rst         in   synchronous active-high reset
//   data_raddr  in   read byte address ([1:0] ignored)
//   data_re     in   read request
//   data_rdata  out  read data, valid one cycle after data_re, then held
//   data_waddr  in   write byte address ([1:0] ignored)
//   data_wdata  in   write data (full word)
//   data_we     in   write request
//   tohost      out  last value accepted into TOHOST
//   halted      out  high once a nonzero TOHOST write has been accepted
//   err         out  sticky flag for unmapped accesses
// -----------------------------------------------------------------------------
module data_mem_responder
   import dmem_pkg::*;
#(
   parameter int          DEPTH_WORDS = 4096,
   parameter logic [31:0] RAM_BASE    = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE   = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] data_raddr,
   input  logic        data_re,
   output logic [31:0] data_rdata,
   input  logic [31:0] data_waddr,
   input  logic [31:0] data_wdata,
   input  logic        data_we,
   output logic [31:0] tohost,
   output logic        halted,
   output logic        err
);

   localparam int AW = $clog2(DEPTH_WORDS);

   // 33-bit bounds so a RAM window ending at 2^32 does not wrap
   localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
   localparam logic [32:0] RAM_HI = RAM_LO + (33'(DEPTH_WORDS) << 2);

   function automatic dec_e decode(input logic [31:0] addr);
      logic [32:0] a;
      a = {1'b0, addr[31:2], 2'b00};
      if (addr[31:4] == MMIO_BASE[31:4]) begin
         return DEC_MMIO;
      end
      if ((a >= RAM_LO) && (a < RAM_HI)) begin
         return DEC_RAM;
      end
      return DEC_NONE;
   endfunction

   state_e      state_q, state_d;
   logic [31:0] tohost_q, tohost_d;
   logic        err_q, err_d;
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] wr_cnt_q, wr_cnt_d;
   dec_e        rd_sel_q, rd_sel_d;
   logic [31:0] mmio_rdata_q, mmio_rdata_d;

   dec_e        rdec, wdec;
   logic [31:0] roff, woff;
   logic        wr_ok, ram_we, ram_re, tohost_wr;
   logic [31:0] tohost_fwd;
   logic [31:0] mmio_val;
   logic [31:0] sram_rdata;
   logic        unused_bits;

   assign rdec   = decode(data_raddr);
   assign wdec   = decode(data_waddr);
   assign roff   = data_raddr - RAM_BASE;
   assign woff   = data_waddr - RAM_BASE;

   // writes only take effect while running and not in reset
   assign wr_ok     = data_we && (state_q == ST_RUN) && !rst;
   assign ram_we    = wr_ok && (wdec == DEC_RAM);
   assign ram_re    = data_re && (rdec == DEC_RAM);
   assign tohost_wr = wr_ok && (wdec == DEC_MMIO) &&
                      ({data_waddr[3:2], 2'b00} == OFF_TOHOST);

   // a TOHOST read alongside an accepted TOHOST write sees the new value
   assign tohost_fwd = tohost_wr ? data_wdata : tohost_q;

   assign unused_bits = ^{roff[31:AW+2], roff[1:0], woff[31:AW+2], woff[1:0]};

   dmem_sram #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_sram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(woff[AW+1:2]),
      .wdata(data_wdata),
      .re   (ram_re),
      .raddr(roff[AW+1:2]),
      .rdata(sram_rdata)
   );

   always_comb begin
      mmio_val = 32'h0;
      case ({data_raddr[3:2], 2'b00})
         OFF_TOHOST: mmio_val = tohost_fwd;
         OFF_CYCLE:  mmio_val = cycle_cnt_q;
         OFF_WRCNT:  mmio_val = wr_cnt_q;       // pre-increment value
         OFF_STATUS: mmio_val = {30'b0, err_q, (state_q == ST_HALTED)};
         default:    mmio_val = 32'h0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      tohost_d     = tohost_q;
      err_d        = err_q;
      cycle_cnt_d  = cycle_cnt_q + 32'd1;
      wr_cnt_d     = wr_cnt_q + {31'b0, ram_we};
      rd_sel_d     = rd_sel_q;
      mmio_rdata_d = mmio_rdata_q;

      if (tohost_wr) begin
         tohost_d = data_wdata;
         if ((state_q == ST_RUN) && (data_wdata != 32'h0)) begin
            state_d = ST_HALTED;
         end
      end

      if ((data_we && (wdec == DEC_NONE)) || (data_re && (rdec == DEC_NONE))) begin
         err_d = 1'b1;
      end

      if (data_re) begin
         rd_sel_d     = rdec;
         mmio_rdata_d = (rdec == DEC_MMIO) ? mmio_val : 32'h0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_RUN;
         tohost_q     <= 32'h0;
         err_q        <= 1'b0;
         cycle_cnt_q  <= 32'h0;
         wr_cnt_q     <= 32'h0;
         rd_sel_q     <= DEC_NONE;
         mmio_rdata_q <= 32'h0;
      end else begin
         state_q      <= state_d;
         tohost_q     <= tohost_d;
         err_q        <= err_d;
         cycle_cnt_q  <= cycle_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_sel_q     <= rd_sel_d;
         mmio_rdata_q <= mmio_rdata_d;
      end
   end

   // both sources are registered; the select only steers between them
   assign data_rdata = (rd_sel_q == DEC_RAM) ? sram_rdata : mmio_rdata_q;
   assign tohost     = tohost_q;
   assign halted     = (state_q == ST_HALTED);
   assign err        = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] data_raddr;
   logic        data_re;
   logic [31:0] data_rdata;
   logic [31:0] data_waddr;
   logic [31:0] data_wdata;
   logic        data_we;
   logic [31:0] tohost;
   logic        halted;
   logic        err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   data_mem_responder dut (
      .clk       (clk),
      .rst       (rst),
      .data_raddr(data_raddr),
      .data_re   (data_re),
      .data_rdata(data_rdata),
      .data_waddr(data_waddr),
      .data_wdata(data_wdata),
      .data_we   (data_we),
      .tohost    (tohost),
      .halted    (halted),
      .err       (err)
   );

   // ---------------- reference model ----------------
   logic [31:0] m_mem   [4096];
   bit          m_known [4096];
   logic [31:0] m_rdata;
   bit          m_rknown;
   logic [31:0] m_tohost;
   bit          m_halted;
   bit          m_err;
   logic [31:0] m_cycle;
   logic [31:0] m_wrcnt;

   function automatic bit t_is_mmio(input logic [31:0] a);
      return a[31:4] == 28'h100_0000;
   endfunction

   function automatic bit t_is_ram(input logic [31:0] a);
      return a < 32'h0000_4000;
   endfunction

   task automatic model(input bit r, input bit re, input logic [31:0] ra,
                        input bit we, input logic [31:0] wa, input logic [31:0] wd);
      if (r) begin
         m_rdata = 0; m_rknown = 1; m_tohost = 0; m_halted = 0;
         m_err = 0; m_cycle = 0; m_wrcnt = 0;
         return;
      end
      if (re) begin
         if (t_is_mmio(ra)) begin
            case (ra[3:2])
               2'd0: m_rdata = (we && !m_halted && t_is_mmio(wa) && wa[3:2] == 2'd0) ? wd : m_tohost;
               2'd1: m_rdata = m_cycle;
               2'd2: m_rdata = m_wrcnt;
               default: m_rdata = {30'b0, m_err, m_halted};
            endcase
            m_rknown = 1;
         end else if (t_is_ram(ra)) begin
            if (we && !m_halted && t_is_ram(wa) && wa[13:2] == ra[13:2]) begin
               m_rdata = wd; m_rknown = 1;
            end else begin
               m_rdata = m_mem[ra[13:2]]; m_rknown = m_known[ra[13:2]];
            end
         end else begin
            m_rdata = 0; m_rknown = 1; m_err = 1;
         end
      end
      if (we) begin
         if (!t_is_mmio(wa) && !t_is_ram(wa)) begin
            m_err = 1;
         end else if (!m_halted) begin
            if (t_is_ram(wa)) begin
               m_mem[wa[13:2]] = wd; m_known[wa[13:2]] = 1; m_wrcnt++;
            end else if (wa[3:2] == 2'd0) begin
               m_tohost = wd;
               if (wd != 0) m_halted = 1;
            end
         end
      end
      m_cycle++;
   endtask

   task automatic step(input bit r, input bit re, input logic [31:0] ra,
                       input bit we, input logic [31:0] wa, input logic [31:0] wd);
      rst = r; data_re = re; data_raddr = ra;
      data_we = we; data_waddr = wa; data_wdata = wd;
      model(r, re, ra, we, wa, wd);
      @(posedge clk);
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=%h", data_rdata, 32'h0); end
      checks++; if (tohost !== 32'h0) begin failures++; $display("FAIL reset_tohost got=%h exp=%h", tohost, 32'h0); end
      checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err); end
      step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic test_write_read();
      step(0, 0, 0, 1, 32'h10, 32'hDEAD_BEEF);
      step(0, 1, 32'h13, 0, 0, 0);
      checks++; if (data_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_rd got=%h exp=%h", data_rdata, 32'hDEAD_BEEF); end
      step(0, 1, 32'h1000_0008, 0, 0, 0);
      checks++; if (data_rdata !== 32'd1) begin failures++; $display("FAIL wrcnt_one got=%h exp=%h", data_rdata, 32'd1); end
      step(0, 0, 32'h10, 0, 0, 0);
      checks++; if (data_rdata !== 32'd1) begin failures++; $display("FAIL rdata_hold got=%h exp=%h", data_rdata, 32'd1); end
   endtask

   task automatic test_forward();
      step(0, 1, 32'h20, 1, 32'h20, 32'h1234_5678);
      checks++; if (data_rdata !== 32'h1234_5678) begin failures++; $display("FAIL fwd got=%h exp=%h", data_rdata, 32'h1234_5678); end
      step(0, 1, 32'h22, 1, 32'h24, 32'h0BAD_F00D);
      checks++; if (data_rdata !== 32'h1234_5678) begin failures++; $display("FAIL fwd_other_word got=%h exp=%h", data_rdata, 32'h1234_5678); end
   endtask

   task automatic test_unmapped();
      step(0, 0, 0, 1, 32'h3FFC, 32'hCAFE_0001);
      step(0, 1, 32'h3FFE, 0, 0, 0);
      checks++; if (data_rdata !== 32'hCAFE_0001) begin failures++; $display("FAIL last_word got=%h exp=%h", data_rdata, 32'hCAFE_0001); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_clean got=%b exp=0", err); end
      step(0, 1, 32'h4000, 0, 0, 0);
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL past_ram_rdata got=%h exp=0", data_rdata); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL past_ram_err got=%b exp=1", err); end
      step(0, 1, 32'h10, 0, 0, 0);
      step(0, 1, 32'h2000_0000, 0, 0, 0);
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL unmapped_rdata got=%h exp=0", data_rdata); end
      step(0, 1, 32'h10, 1, 32'h30, 32'h3333_3333);
      checks++; if (data_rdata !== 32'hDEAD_BEEF) begin failures++; $display("FAIL after_err_rd got=%h exp=%h", data_rdata, 32'hDEAD_BEEF); end
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err); end
      step(0, 1, 32'h1000_000C, 0, 0, 0);
      checks++; if (data_rdata !== 32'h2) begin failures++; $display("FAIL status got=%h exp=%h", data_rdata, 32'h2); end
   endtask

   task automatic test_cycle();
      logic [31:0] v1, v2;
      step(1, 0, 0, 0, 0, 0);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_after_rst got=%b exp=0", err); end
      step(0, 1, 32'h1000_0004, 0, 0, 0);
      v1 = data_rdata;
      checks++; if (v1 !== m_rdata) begin failures++; $display("FAIL cycle_first got=%h exp=%h", v1, m_rdata); end
      repeat (4) step(0, 0, 0, 0, 0, 0);
      step(0, 1, 32'h1000_0004, 0, 0, 0);
      v2 = data_rdata;
      checks++; if (v2 - v1 !== 32'd5) begin failures++; $display("FAIL cycle_delta got=%0d exp=5", v2 - v1); end
      step(0, 0, 0, 1, 32'h1000_0004, 32'hFFFF_0000);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL ro_write_err got=%b exp=0", err); end
      step(0, 1, 32'h1000_0004, 0, 0, 0);
      checks++; if (data_rdata !== m_rdata) begin failures++; $display("FAIL cycle_ro got=%h exp=%h", data_rdata, m_rdata); end
   endtask

   task automatic test_reset_write();
      step(0, 0, 0, 1, 32'h50, 32'h5555_AAAA);
      step(0, 1, 32'h3000_0000, 0, 0, 0);
      step(0, 1, 32'h50, 0, 0, 0);
      checks++; if (data_rdata !== 32'h5555_AAAA) begin failures++; $display("FAIL pre_rst_rd got=%h exp=%h", data_rdata, 32'h5555_AAAA); end
      step(1, 0, 0, 1, 32'h50, 32'hBAD0_BAD0);
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL rstw_rdata got=%h exp=0", data_rdata); end
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL rstw_err got=%b exp=0", err); end
      checks++; if (halted !== 1'b0 || tohost !== 32'h0) begin failures++; $display("FAIL rstw_halt got=%b/%h exp=0/0", halted, tohost); end
      step(0, 1, 32'h50, 0, 0, 0);
      checks++; if (data_rdata !== 32'h5555_AAAA) begin failures++; $display("FAIL rstw_ram got=%h exp=%h", data_rdata, 32'h5555_AAAA); end
      step(0, 1, 32'h1000_0008, 0, 0, 0);
      checks++; if (data_rdata !== 32'h0) begin failures++; $display("FAIL rstw_wrcnt got=%h exp=0", data_rdata); end
   endtask

   task automatic test_halt();
      logic [31:0] wc0;
      step(0, 0, 0, 1, 32'h40, 32'h1111_1111);
      step(0, 1, 32'h1000_0008, 0, 0, 0);
      wc0 = data_rdata;
      checks++; if (wc0 !== m_rdata) begin failures++; $display("FAIL halt_wrcnt0 got=%h exp=%h", wc0, m_rdata); end
      step(0, 0, 0, 1, 32'h1000_0000, 32'h0);
      checks++; if (halted !== 1'b0 || tohost !== 32'h0) begin failures++; $display("FAIL tohost_zero got=%b/%h exp=0/0", halted, tohost); end
      step(0, 1, 32'h1000_0000, 1, 32'h1000_0000, 32'h1);
      checks++; if (data_rdata !== 32'h1) begin failures++; $display("FAIL tohost_fwd got=%h exp=1", data_rdata); end
      checks++; if (halted !== 1'b1 || tohost !== 32'h1) begin failures++; $display("FAIL halt_set got=%b/%h exp=1/1", halted, tohost); end
      step(0, 0, 0, 1, 32'h40, 32'hAA);
      step(0, 1, 32'h40, 0, 0, 0);
      checks++; if (data_rdata !== 32'h1111_1111) begin failures++; $display("FAIL halt_drop got=%h exp=%h", data_rdata, 32'h1111_1111); end
      step(0, 1, 32'h1000_0008, 1, 32'h1000_0000, 32'h7);
      checks++; if (data_rdata !== wc0) begin failures++; $display("FAIL halt_wrcnt got=%h exp=%h", data_rdata, wc0); end
      checks++; if (halted !== 1'b1 || tohost !== 32'h1) begin failures++; $display("FAIL halt_stay got=%b/%h exp=1/1", halted, tohost); end
      step(0, 1, 32'h1000_000C, 0, 0, 0);
      checks++; if (data_rdata !== m_rdata) begin failures++; $display("FAIL halt_status got=%h exp=%h", data_rdata, m_rdata); end
   endtask

   function automatic logic [31:0] rnd_addr();
      int k;
      k = $urandom_range(0, 11);
      if (k < 7) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(0, 3));
      if (k < 10) return 32'h1000_0000 | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
      if (k == 10) return 32'h0000_4000 + (32'($urandom_range(0, 255)) << 2);
      return 32'h1000_0010 + 32'($urandom_range(0, 15));
   endfunction

   task automatic test_random();
      logic [31:0] ra, wa, wd;
      bit re, we;
      step(1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 64; i++) step(0, 0, 0, 1, 32'(i) << 2, $urandom);
      for (int i = 0; i < 400; i++) begin
         re = ($urandom_range(0, 3) != 0);
         we = ($urandom_range(0, 2) != 0);
         ra = rnd_addr();
         wa = ($urandom_range(0, 3) == 0) ? ra : rnd_addr();
         wd = $urandom;
         if (t_is_mmio(wa) && wa[3:2] == 2'd0 && i < 300) wd = 0;
         step(0, re, ra, we, wa, wd);
         if (m_rknown) begin
            checks++; if (data_rdata !== m_rdata) begin failures++; $display("FAIL rnd_rdata cyc=%0d got=%h exp=%h", i, data_rdata, m_rdata); end
         end
         checks++; if (err !== m_err) begin failures++; $display("FAIL rnd_err cyc=%0d got=%b exp=%b", i, err, m_err); end
         checks++; if (halted !== m_halted) begin failures++; $display("FAIL rnd_halted cyc=%0d got=%b exp=%b", i, halted, m_halted); end
         checks++; if (tohost !== m_tohost) begin failures++; $display("FAIL rnd_tohost cyc=%0d got=%h exp=%h", i, tohost, m_tohost); end
      end
   endtask

   initial begin
      rst = 1; data_re = 0; data_raddr = 0; data_we = 0; data_waddr = 0; data_wdata = 0;
      m_rknown = 0;
      for (int i = 0; i < 4096; i++) m_known[i] = 0;
      test_reset();
      test_write_read();
      test_forward();
      test_unmapped();
      test_cycle();
      test_reset_write();
      test_halt();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
